// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: width/stage bookkeeping for the pipelined ripple-carry adders.
package arith_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit chunk_ok(input int w, input int c);
    return (c > 0) && (w >= c) && ((w % c) == 0);
  endfunction

  // Enabled cycles from operand capture to result: input register plus one per slice.
  function automatic int stg_lat(input int w, input int c);
    return (w / c) + 1;
  endfunction

  // Bit offset of stage k's leftover B operand in the packed skew line; stage k keeps w-k*c bits.
  function automatic int y_off(input int k, input int w, input int c);
    return k * w - (c * k * (k - 1)) / 2;
  endfunction

  localparam int  DEF_WIDTH    = 16;
  localparam int  DEF_CHUNK    = 4;
  localparam bit  DEF_CHUNK_OK = chunk_ok(DEF_WIDTH, DEF_CHUNK);
  localparam int  STG_LAT      = stg_lat(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/pip_rca_chunk.sv
// Combinational CHUNK-bit ripple adder slice; c_msb exposes the carry into the top bit.
module pip_rca_chunk
  import arith_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] cy;

  assign cy[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign co    = cy[CHUNK];
  assign c_msb = cy[CHUNK-1];

endmodule

// File: rtl/pip_rca_param.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice resolved per stage,
// with valid tagging, global stall and signed-overflow flag.
module pip_rca_param
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int NSTG = WIDTH / CHUNK;
  localparam int YW   = y_off(NSTG, WIDTH, CHUNK);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pip_rca_param: WIDTH must be a non-zero multiple of CHUNK");
  end

  // x_q[k] = {slice sums done so far, A bits not yet consumed}; rotates right by CHUNK per stage
  logic [WIDTH-1:0] x_q [0:NSTG];
  logic [WIDTH-1:0] x_d [0:NSTG];
  logic [YW-1:0]    y_q, y_d;
  logic [NSTG:0]    c_q, c_d;
  logic [NSTG:0]    v_q, v_d;
  logic             ovf_q, ovf_d;
  logic [NSTG-1:0]  sl_co, sl_cm;
  logic [NSTG-1:0]  cm_unused;

  assign x_d[0]           = a;
  assign y_d[WIDTH-1:0]   = sub ? ~b : b;
  assign c_d[0]           = sub ? ~cin : cin;
  assign v_d[0]           = in_valid;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int YO = y_off(k, WIDTH, CHUNK);
    logic [CHUNK-1:0] sum_k;

    pip_rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (x_q[k][CHUNK-1:0]),
      .b     (y_q[YO +: CHUNK]),
      .ci    (c_q[k]),
      .s     (sum_k),
      .co    (sl_co[k]),
      .c_msb (sl_cm[k])
    );

    assign x_d[k+1] = (x_q[k] >> CHUNK) | (WIDTH'(sum_k) << (WIDTH - CHUNK));
    assign c_d[k+1] = sl_co[k];
    assign v_d[k+1] = v_q[k];
  end

  // B skew line: each stage drops the slice it just consumed.
  for (genvar k = 1; k < NSTG; k++) begin : g_ydly
    localparam int SRC = y_off(k - 1, WIDTH, CHUNK) + CHUNK;
    localparam int DST = y_off(k, WIDTH, CHUNK);
    localparam int RW  = WIDTH - k * CHUNK;
    assign y_d[DST +: RW] = y_q[SRC +: RW];
  end

  // Only the top slice's carry-into-MSB feeds overflow.
  assign cm_unused = sl_cm;
  assign ovf_d     = sl_cm[NSTG-1] ^ sl_co[NSTG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '{default: '0};
      y_q   <= '0;
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      x_q   <= x_d;
      y_q   <= y_d;
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign s         = x_q[NSTG];
  assign cout      = c_q[NSTG];
  assign ovf       = ovf_q;
  assign out_valid = v_q[NSTG];

endmodule

// File: tb/tb_pip_rca_param.sv
// Directed bench for pip_rca_param: default 16/4 instance plus an 8/2 instance.
module tb_pip_rca_param;

  logic        clk;
  logic        rst_n;
  logic        en;

  logic        iv16, cin16, sub16;
  logic [15:0] a16, b16;
  logic [15:0] s16;
  logic        co16, ov16, vo16;

  logic        iv8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic [7:0]  s8;
  logic        co8, ov8, vo8;

  int total = 0;
  int bad   = 0;

  logic [7:0] ta [6];
  logic [7:0] tb [6];
  logic       tc [6];
  logic       tsub [6];
  logic       tv [6];
  logic [7:0] es [6];
  logic       ec [6];
  logic       eo [6];

  pip_rca_param #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .s(s16), .cout(co16), .ovf(ov16), .out_valid(vo16)
  );

  pip_rca_param #(.WIDTH(8), .CHUNK(2)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .s(s8), .cout(co8), .ovf(ov8), .out_valid(vo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
    iv16 = 1'b1; a16 = a; b16 = b; cin16 = c; sub16 = sb;
  endtask

  task automatic idle();
    iv16 = 1'b0; a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0; sub16 = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] s, input logic c, input logic o);
    chk({tag, ".valid"}, 32'(vo16), 32'd1);
    chk({tag, ".s"},     32'(s16),  32'(s));
    chk({tag, ".cout"},  32'(co16), 32'(c));
    chk({tag, ".ovf"},   32'(ov16), 32'(o));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    idle();
    iv8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; sub8 = 1'b0;

    // reset state before any clock edge
    #2;
    chk("rst.s",     32'(s16),  32'd0);
    chk("rst.cout",  32'(co16), 32'd0);
    chk("rst.ovf",   32'(ov16), 32'd0);
    chk("rst.valid", 32'(vo16), 32'd0);
    chk("rst.valid8", 32'(vo8), 32'd0);
    #6 rst_n = 1'b1;
    tick();

    // single issue, latency 5, one-cycle pulse
    issue(16'h6F77, 16'h7178, 1'b0, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    chk("single.early", 32'(vo16), 32'd0);
    tick();
    expect_out("single", 16'hE0EF, 1'b0, 1'b1);
    tick();
    chk("single.pulse", 32'(vo16), 32'd0);

    // back-to-back, full carry ripple on the third
    issue(16'h3000, 16'hF000, 1'b0, 1'b0); tick();
    issue(16'h0001, 16'h0003, 1'b1, 1'b0); tick();
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0); tick();
    idle(); tick();
    chk("b2b.early", 32'(vo16), 32'd0);
    tick(); expect_out("b2b0", 16'h2000, 1'b1, 1'b0);
    tick(); expect_out("b2b1", 16'h0005, 1'b0, 1'b0);
    tick(); expect_out("b2b2", 16'h0000, 1'b1, 1'b0);
    tick(); chk("b2b.drain", 32'(vo16), 32'd0);

    // subtract
    issue(16'h0005, 16'h0007, 1'b0, 1'b1); tick();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1); tick();
    idle();
    repeat (3) tick();
    expect_out("sub0", 16'hFFFE, 1'b0, 1'b0);
    tick(); expect_out("sub1", 16'h7FFF, 1'b1, 1'b1);
    tick(); chk("sub.drain", 32'(vo16), 32'd0);

    // stall with a result on the outputs; junk issued while stalled must be ignored
    issue(16'h1234, 16'h1111, 1'b0, 1'b0); tick();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); tick();
    issue(16'h0000, 16'h0001, 1'b0, 1'b1); tick();
    idle(); tick(); tick();
    expect_out("stall.x", 16'h2345, 1'b0, 1'b0);
    en = 1'b0;
    issue(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall.hold", 16'h2345, 1'b0, 1'b0);
    end
    en = 1'b1;
    idle();
    tick(); expect_out("stall.y", 16'h8000, 1'b0, 1'b1);
    tick(); expect_out("stall.z", 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.drain", 32'(vo16), 32'd0);
    end

    // asynchronous reset with operations in flight
    issue(16'h4000, 16'h4000, 1'b0, 1'b0); tick();
    issue(16'h0F0F, 16'hF0F0, 1'b1, 1'b0); tick();
    issue(16'h1111, 16'h2222, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    expect_out("rstmid.p", 16'h8000, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid.s",     32'(s16),  32'd0);
    chk("rstmid.cout",  32'(co16), 32'd0);
    chk("rstmid.ovf",   32'(ov16), 32'd0);
    chk("rstmid.valid", 32'(vo16), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rstmid.stale", 32'(vo16), 32'd0);
    end
    issue(16'h0102, 16'h0304, 1'b1, 1'b0); tick();
    idle();
    repeat (3) tick();
    chk("rstmid.early", 32'(vo16), 32'd0);
    tick(); expect_out("rstmid.new", 16'h0407, 1'b0, 1'b0);
    tick(); chk("rstmid.drain", 32'(vo16), 32'd0);

    // 8-bit / 2-bit-chunk instance with a bubble
    ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0; tsub[0] = 1'b0; tv[0] = 1'b1; es[0] = 8'h00; ec[0] = 1'b1; eo[0] = 1'b0;
    ta[1] = 8'h7F; tb[1] = 8'h01; tc[1] = 1'b0; tsub[1] = 1'b0; tv[1] = 1'b1; es[1] = 8'h80; ec[1] = 1'b0; eo[1] = 1'b1;
    ta[2] = 8'h12; tb[2] = 8'h34; tc[2] = 1'b0; tsub[2] = 1'b0; tv[2] = 1'b0; es[2] = 8'h00; ec[2] = 1'b0; eo[2] = 1'b0;
    ta[3] = 8'h80; tb[3] = 8'h01; tc[3] = 1'b0; tsub[3] = 1'b1; tv[3] = 1'b1; es[3] = 8'h7F; ec[3] = 1'b1; eo[3] = 1'b1;
    ta[4] = 8'h03; tb[4] = 8'h05; tc[4] = 1'b1; tsub[4] = 1'b1; tv[4] = 1'b1; es[4] = 8'hFD; ec[4] = 1'b0; eo[4] = 1'b0;
    ta[5] = 8'hAA; tb[5] = 8'h55; tc[5] = 1'b1; tsub[5] = 1'b0; tv[5] = 1'b1; es[5] = 8'h00; ec[5] = 1'b1; eo[5] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        iv8 = tv[c]; a8 = ta[c]; b8 = tb[c]; cin8 = tc[c]; sub8 = tsub[c];
      end else begin
        iv8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; sub8 = 1'b0;
      end
      tick();
      if (c >= 4 && c < 10) begin
        chk("w8.valid", 32'(vo8), 32'(tv[c-4]));
        if (tv[c-4]) begin
          chk("w8.s",    32'(s8),  32'(es[c-4]));
          chk("w8.cout", 32'(co8), 32'(ec[c-4]));
          chk("w8.ovf",  32'(ov8), 32'(eo[c-4]));
        end
      end else begin
        chk("w8.idle", 32'(vo8), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
